uart_tx_fifo_ctrl: RTL and testbench

Transmit-side FIFO and sequencer for the UART 16550 core. It buffers host writes to THR in a DEPTH-entry FIFO, or a single holding register in 16450 mode. It feeds bytes one at a time into the `tx` serializer through its `write_thr`/`thr_data` handshake and paces the feed on `thr_empty`/`tx_done`. It also generates the LSR THRE/TEMT status bits and the THRE interrupt event for the register block.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo_ctrl_if.sv | 32 +++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: sequencer states and default sizing constants.
package uart_pkg;

    localparam int unsigned UART_FIFO_DEPTH = 16;
    localparam int unsigned UART_DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACCEPT = 2'd2,
        BUSY   = 2'd3
    } tx_seq_state_e;

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Host/serializer-facing signal bundle of the transmit FIFO controller.
interface uart_tx_fifo_ctrl_if import uart_pkg::*; #(
    parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
    parameter int unsigned DATA_W = UART_DATA_W
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              fifo_en;
    logic              fifo_clr;
    logic              tx_thr_empty;
    logic              tx_done;
    logic              write_thr;
    logic [DATA_W-1:0] thr_data;
    logic              thre;
    logic              temt;
    logic              thre_evt;
    logic [LVL_W-1:0]  tx_level;
    logic              wr_ovf;

    modport master (
        output wr_en, wr_data, fifo_en, fifo_clr, tx_thr_empty, tx_done,
        input  write_thr, thr_data, thre, temt, thre_evt, tx_level, wr_ovf
    );

    modport slave (
        input  wr_en, wr_data, fifo_en, fifo_clr, tx_thr_empty, tx_done,
        output write_thr, thr_data, thre, temt, thre_evt, tx_level, wr_ovf
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with runtime capacity limit; clear beats push and pop.
module uart_sync_fifo #(
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic [LVL_W-1:0]  cap,
    output logic [DATA_W-1:0] head_c,
    output logic [LVL_W-1:0]  level,
    output logic [LVL_W-1:0]  level_nxt_c,
    output logic              ovf_c
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Accept/drop decisions; a pop in the same cycle frees a slot for a push.
    always_comb begin
        pop_ok      = pop && !clr && (level != '0);
        push_ok     = push && !clr && ((level < cap) || pop_ok);
        ovf_c       = push && !clr && !push_ok;
        level_nxt_c = level;
        if (clr) begin
            level_nxt_c = '0;
        end else if (push_ok && !pop_ok) begin
            level_nxt_c = level + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_nxt_c = level - LVL_W'(1);
        end
    end

    assign head_c = mem[rd_ptr];

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_nxt_c;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO, byte sequencer towards the serializer, and LSR THRE/TEMT status.
module uart_tx_fifo_ctrl import uart_pkg::*; #(
    parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_fifo_ctrl_if.slave  bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    tx_seq_state_e     state_q;
    tx_seq_state_e     state_d;
    logic              fifo_en_q;
    logic              flush_c;
    logic              pop_c;
    logic              have_data_c;
    logic [LVL_W-1:0]  cap_c;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt_c;
    logic [DATA_W-1:0] head_c;
    logic              ovf_c;
    logic              thre_c;
    logic              write_thr_q;
    logic [DATA_W-1:0] thr_data_q;
    logic              thre_evt_q;
    logic              wr_ovf_q;

    // A mode change invalidates the queue exactly like an explicit clear.
    assign flush_c = bus.fifo_clr || (bus.fifo_en != fifo_en_q);
    assign cap_c   = bus.fifo_en ? LVL_W'(DEPTH) : LVL_W'(1);

    // Data will be present next cycle: a push this cycle counts, no bypass to pop.
    assign have_data_c = !flush_c && ((level != '0) || (bus.wr_en && (level < cap_c)));

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (flush_c),
        .push        (bus.wr_en),
        .din         (bus.wr_data),
        .pop         (pop_c),
        .cap         (cap_c),
        .head_c      (head_c),
        .level       (level),
        .level_nxt_c (level_nxt_c),
        .ovf_c       (ovf_c)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state; a clear during LOAD cancels the hand-off.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (have_data_c && bus.tx_thr_empty) state_d = LOAD;
            end
            LOAD: begin
                if (flush_c) begin
                    state_d = IDLE;
                end else begin
                    pop_c   = 1'b1;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (!bus.tx_thr_empty) state_d = BUSY;
            end
            BUSY: begin
                if (bus.tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered strobes and data towards the serializer and register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_en_q   <= 1'b0;
            write_thr_q <= 1'b0;
            thr_data_q  <= '0;
            thre_evt_q  <= 1'b0;
            wr_ovf_q    <= 1'b0;
        end else begin
            fifo_en_q   <= bus.fifo_en;
            write_thr_q <= pop_c;
            if (pop_c) thr_data_q <= head_c;
            thre_evt_q  <= (level != '0) && (level_nxt_c == '0);
            wr_ovf_q    <= ovf_c;
        end
    end

    assign thre_c        = (level == '0);
    assign bus.thre      = thre_c;
    assign bus.temt      = thre_c && (state_q == IDLE) && bus.tx_thr_empty;
    assign bus.write_thr = write_thr_q;
    assign bus.thr_data  = thr_data_q;
    assign bus.thre_evt  = thre_evt_q;
    assign bus.tx_level  = level;
    assign bus.wr_ovf    = wr_ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed self-checking bench for uart_tx_fifo_ctrl with a simple serializer model.
module tb_uart_tx_fifo_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tx_len = 4;
    logic tx_block = 1'b0;
    logic tx_idle_q;
    logic tx_done_q;
    int   tx_cnt;
    int   evt_cnt;
    logic [7:0] got [$];

    uart_tx_fifo_ctrl_if #(.DEPTH(16), .DATA_W(8)) bus ();

    uart_tx_fifo_ctrl #(.DEPTH(16), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Serializer model: busy for tx_len cycles after each load, then tx_done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_idle_q <= 1'b1;
            tx_done_q <= 1'b0;
            tx_cnt    <= 0;
        end else begin
            tx_done_q <= 1'b0;
            if (bus.write_thr) begin
                tx_idle_q <= 1'b0;
                tx_cnt    <= tx_len;
            end else if (tx_cnt == 1) begin
                tx_done_q <= 1'b1;
                tx_idle_q <= 1'b1;
                tx_cnt    <= 0;
            end else if (tx_cnt > 1) begin
                tx_cnt <= tx_cnt - 1;
            end
        end
    end

    assign bus.tx_thr_empty = tx_idle_q & ~tx_block;
    assign bus.tx_done      = tx_done_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until the whole path is idle, collecting every byte handed to tx.
    task automatic drain(input int budget);
        int quiet;
        bit pending;
        bit done;
        quiet = 0; pending = 1'b0; done = 1'b0; evt_cnt = 0;
        got.delete();
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (bus.thre_evt) evt_cnt++;
            if (bus.tx_done) pending = 1'b0;
            if (bus.write_thr) begin
                n_cmp++;
                if (pending) begin n_err++; $display("FAIL write_thr_before_tx_done got=1 exp=0 data=%0h", bus.thr_data); end
                pending = 1'b1;
                got.push_back(bus.thr_data);
            end
            quiet = bus.temt ? quiet + 1 : 0;
            if (quiet >= 6) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL drain_timeout got=busy exp=idle within %0d cycles", budget); end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #6;
        n_cmp++; if (bus.write_thr !== 1'b0) begin n_err++; $display("FAIL rst_write_thr got=%0h exp=0", bus.write_thr); end
        n_cmp++; if (bus.thr_data !== 8'h00) begin n_err++; $display("FAIL rst_thr_data got=%0h exp=0", bus.thr_data); end
        n_cmp++; if (bus.thre !== 1'b1) begin n_err++; $display("FAIL rst_thre got=%0h exp=1", bus.thre); end
        n_cmp++; if (bus.temt !== 1'b1) begin n_err++; $display("FAIL rst_temt got=%0h exp=1", bus.temt); end
        n_cmp++; if (bus.thre_evt !== 1'b0) begin n_err++; $display("FAIL rst_thre_evt got=%0h exp=0", bus.thre_evt); end
        n_cmp++; if (bus.tx_level !== 5'd0) begin n_err++; $display("FAIL rst_tx_level got=%0d exp=0", bus.tx_level); end
        n_cmp++; if (bus.wr_ovf !== 1'b0) begin n_err++; $display("FAIL rst_wr_ovf got=%0h exp=0", bus.wr_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.thre_evt !== 1'b0) begin n_err++; $display("FAIL post_rst_thre_evt got=%0h exp=0", bus.thre_evt); end
    endtask

    task automatic test_single_byte();
        bit saw_done;
        bit temt_early;
        tx_len = 4;
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.tx_level !== 5'd1) begin n_err++; $display("FAIL single_level_n1 got=%0d exp=1", bus.tx_level); end
        n_cmp++; if (bus.thre !== 1'b0) begin n_err++; $display("FAIL single_thre_n1 got=%0h exp=0", bus.thre); end
        n_cmp++; if (bus.write_thr !== 1'b0) begin n_err++; $display("FAIL single_write_thr_n1 got=%0h exp=0", bus.write_thr); end
        n_cmp++; if (bus.temt !== 1'b0) begin n_err++; $display("FAIL single_temt_n1 got=%0h exp=0", bus.temt); end
        tick();
        n_cmp++; if (bus.write_thr !== 1'b1) begin n_err++; $display("FAIL single_write_thr_n2 got=%0h exp=1", bus.write_thr); end
        n_cmp++; if (bus.thr_data !== 8'hA5) begin n_err++; $display("FAIL single_thr_data got=%0h exp=a5", bus.thr_data); end
        n_cmp++; if (bus.thre !== 1'b1) begin n_err++; $display("FAIL single_thre_n2 got=%0h exp=1", bus.thre); end
        n_cmp++; if (bus.thre_evt !== 1'b1) begin n_err++; $display("FAIL single_thre_evt got=%0h exp=1", bus.thre_evt); end
        n_cmp++; if (bus.temt !== 1'b0) begin n_err++; $display("FAIL single_temt_n2 got=%0h exp=0", bus.temt); end
        tick();
        n_cmp++; if (bus.write_thr !== 1'b0) begin n_err++; $display("FAIL single_write_thr_n3 got=%0h exp=0", bus.write_thr); end
        n_cmp++; if (bus.thre_evt !== 1'b0) begin n_err++; $display("FAIL single_thre_evt_n3 got=%0h exp=0", bus.thre_evt); end
        saw_done = 1'b0; temt_early = 1'b0;
        for (int i = 0; i < 20 && !saw_done; i++) begin
            if (bus.temt) temt_early = 1'b1;
            if (bus.tx_done) saw_done = 1'b1;
            else tick();
        end
        n_cmp++; if (saw_done !== 1'b1) begin n_err++; $display("FAIL single_tx_done_timeout got=0 exp=1"); end
        n_cmp++; if (temt_early !== 1'b0) begin n_err++; $display("FAIL single_temt_before_done got=1 exp=0"); end
        tick();
        n_cmp++; if (bus.temt !== 1'b1) begin n_err++; $display("FAIL single_temt_after_done got=%0h exp=1", bus.temt); end
    endtask

    task automatic test_burst();
        tx_len = 4;
        tx_block = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            tick();
        end
        n_cmp++; if (bus.tx_level !== 5'd16) begin n_err++; $display("FAIL burst_level_full got=%0d exp=16", bus.tx_level); end
        n_cmp++; if (bus.wr_ovf !== 1'b0) begin n_err++; $display("FAIL burst_ovf_early got=%0h exp=0", bus.wr_ovf); end
        bus.wr_data = 8'hFF;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.wr_ovf !== 1'b1) begin n_err++; $display("FAIL burst_ovf got=%0h exp=1", bus.wr_ovf); end
        n_cmp++; if (bus.tx_level !== 5'd16) begin n_err++; $display("FAIL burst_level_after_ovf got=%0d exp=16", bus.tx_level); end
        tick();
        n_cmp++; if (bus.wr_ovf !== 1'b0) begin n_err++; $display("FAIL burst_ovf_one_cycle got=%0h exp=0", bus.wr_ovf); end
        tx_block = 1'b0;
        drain(400);
        n_cmp++; if (got.size() != 16) begin n_err++; $display("FAIL burst_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++; if (got[i] !== 8'(i)) begin n_err++; $display("FAIL burst_order[%0d] got=%0h exp=%0h", i, got[i], i); end
        end
    endtask

    task automatic test_16450();
        bus.fifo_en = 1'b0;
        tick();
        tx_len = 10;
        bus.wr_en = 1'b1; bus.wr_data = 8'h33;
        tick();
        bus.wr_en = 1'b0;
        tick();
        n_cmp++; if (bus.write_thr !== 1'b1 || bus.thr_data !== 8'h33) begin n_err++; $display("FAIL m16450_first_load got=%0h/%0h exp=1/33", bus.write_thr, bus.thr_data); end
        bus.wr_en = 1'b1; bus.wr_data = 8'h11;
        tick();
        bus.wr_data = 8'h22;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.wr_ovf !== 1'b1) begin n_err++; $display("FAIL m16450_ovf got=%0h exp=1", bus.wr_ovf); end
        n_cmp++; if (bus.tx_level !== 5'd1) begin n_err++; $display("FAIL m16450_level got=%0d exp=1", bus.tx_level); end
        drain(200);
        n_cmp++; if (got.size() != 1) begin n_err++; $display("FAIL m16450_busy_count got=%0d exp=1", got.size()); end
        n_cmp++; if (got.size() > 0 && got[0] !== 8'h11) begin n_err++; $display("FAIL m16450_busy_byte got=%0h exp=11", got[0]); end
        bus.wr_en = 1'b1; bus.wr_data = 8'h11;
        tick();
        bus.wr_data = 8'h22;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.wr_ovf !== 1'b0) begin n_err++; $display("FAIL m16450_loaded_ovf got=%0h exp=0", bus.wr_ovf); end
        n_cmp++; if (bus.write_thr !== 1'b1 || bus.thr_data !== 8'h11) begin n_err++; $display("FAIL m16450_loaded_byte got=%0h/%0h exp=1/11", bus.write_thr, bus.thr_data); end
        n_cmp++; if (bus.tx_level !== 5'd1) begin n_err++; $display("FAIL m16450_loaded_level got=%0d exp=1", bus.tx_level); end
        drain(200);
        n_cmp++; if (got.size() != 1 || got[0] !== 8'h22) begin n_err++; $display("FAIL m16450_second_byte got_n=%0d exp_n=1 byte exp=22", got.size()); end
    endtask

    task automatic test_flush();
        bus.fifo_en = 1'b1;
        tick();
        tx_len = 12;
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
            tick();
        end
        n_cmp++; if (bus.tx_level !== 5'd7) begin n_err++; $display("FAIL flush_level_before got=%0d exp=7", bus.tx_level); end
        bus.wr_data = 8'h99; bus.fifo_clr = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.fifo_clr = 1'b0;
        n_cmp++; if (bus.tx_level !== 5'd0) begin n_err++; $display("FAIL flush_level got=%0d exp=0", bus.tx_level); end
        n_cmp++; if (bus.thre_evt !== 1'b1) begin n_err++; $display("FAIL flush_thre_evt got=%0h exp=1", bus.thre_evt); end
        n_cmp++; if (bus.wr_ovf !== 1'b0) begin n_err++; $display("FAIL flush_clr_wr_ovf got=%0h exp=0", bus.wr_ovf); end
        n_cmp++; if (bus.temt !== 1'b0) begin n_err++; $display("FAIL flush_temt_busy got=%0h exp=0", bus.temt); end
        drain(200);
        n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL flush_extra_write_thr got=%0d exp=0", got.size()); end
        n_cmp++; if (evt_cnt != 0) begin n_err++; $display("FAIL flush_extra_thre_evt got=%0d exp=0", evt_cnt); end
    endtask

    task automatic test_full_push_pop();
        tx_len = 4;
        tx_block = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h80 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.tx_level !== 5'd16) begin n_err++; $display("FAIL fullpp_level_full got=%0d exp=16", bus.tx_level); end
        tx_block = 1'b0;
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'h90;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.wr_ovf !== 1'b0) begin n_err++; $display("FAIL fullpp_wr_ovf got=%0h exp=0", bus.wr_ovf); end
        n_cmp++; if (bus.tx_level !== 5'd16) begin n_err++; $display("FAIL fullpp_level got=%0d exp=16", bus.tx_level); end
        n_cmp++; if (bus.write_thr !== 1'b1 || bus.thr_data !== 8'h80) begin n_err++; $display("FAIL fullpp_load got=%0h/%0h exp=1/80", bus.write_thr, bus.thr_data); end
        drain(400);
        n_cmp++; if (got.size() != 16) begin n_err++; $display("FAIL fullpp_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++; if (got[i] !== 8'(8'h81 + i)) begin n_err++; $display("FAIL fullpp_order[%0d] got=%0h exp=%0h", i, got[i], 8'h81 + i); end
        end
    endtask

    task automatic test_async_reset();
        int loads;
        tx_len = 20;
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h51 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.tx_level !== 5'd5) begin n_err++; $display("FAIL arst_level_before got=%0d exp=5", bus.tx_level); end
        n_cmp++; if (bus.thr_data !== 8'h51) begin n_err++; $display("FAIL arst_thr_data_before got=%0h exp=51", bus.thr_data); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.write_thr !== 1'b0) begin n_err++; $display("FAIL arst_write_thr got=%0h exp=0", bus.write_thr); end
        n_cmp++; if (bus.thr_data !== 8'h00) begin n_err++; $display("FAIL arst_thr_data got=%0h exp=0", bus.thr_data); end
        n_cmp++; if (bus.thre !== 1'b1) begin n_err++; $display("FAIL arst_thre got=%0h exp=1", bus.thre); end
        n_cmp++; if (bus.temt !== 1'b1) begin n_err++; $display("FAIL arst_temt got=%0h exp=1", bus.temt); end
        n_cmp++; if (bus.thre_evt !== 1'b0) begin n_err++; $display("FAIL arst_thre_evt got=%0h exp=0", bus.thre_evt); end
        n_cmp++; if (bus.tx_level !== 5'd0) begin n_err++; $display("FAIL arst_tx_level got=%0d exp=0", bus.tx_level); end
        n_cmp++; if (bus.wr_ovf !== 1'b0) begin n_err++; $display("FAIL arst_wr_ovf got=%0h exp=0", bus.wr_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        loads = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.write_thr) loads++;
        end
        n_cmp++; if (loads != 0) begin n_err++; $display("FAIL arst_spurious_load got=%0d exp=0", loads); end
        n_cmp++; if (bus.tx_level !== 5'd0) begin n_err++; $display("FAIL arst_level_after got=%0d exp=0", bus.tx_level); end
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.fifo_en  = 1'b1;
        bus.fifo_clr = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_16450();
        test_flush();
        test_full_push_pop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
